// File: rtl/kmap_sweep_checker.sv
// kmap_sweep_checker: sweeps all 16 inputs through SOP/POS K-map blocks, captures the POS truth vector and counts disagreements
module kmap_sweep_checker #(
   parameter int          SETTLE = 1,
   parameter logic [15:0] EXPECT = 16'h5057
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sop_in,
   input  logic        pos_in,
   output logic        x1,
   output logic        x2,
   output logic        x3,
   output logic        x4,
   output logic        busy,
   output logic        done,
   output logic [15:0] truth,
   output logic [4:0]  mismatch_cnt,
   output logic        pass
);
   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
   localparam logic [3:0] last = 4'(SETTLE - 1);
   state_t      state;
   logic [3:0]  idx;
   logic [3:0]  wcnt;
   logic [15:0] truth_nxt;
   logic [4:0]  cnt_nxt;
   assign {x1, x2, x3, x4} = state == IDLE ? 4'h0 : idx;
   assign busy = state == APPLY;
   assign done = state == DONE;
   assign cnt_nxt = mismatch_cnt + {4'b0, sop_in ^ pos_in};
   always_comb begin
      truth_nxt = truth;
      truth_nxt[idx] = pos_in;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         wcnt         <= '0;
         truth        <= '0;
         mismatch_cnt <= '0;
         pass         <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state        <= APPLY;
               idx          <= '0;
               wcnt         <= '0;
               truth        <= '0;
               mismatch_cnt <= '0;
               pass         <= 1'b0;
            end
            APPLY: if (wcnt == last) begin
               truth        <= truth_nxt;
               mismatch_cnt <= cnt_nxt;
               wcnt         <= '0;
               // pass uses the next-state values so the vector-15 sample is included
               if (idx == 4'hf) begin
                  state <= DONE;
                  pass  <= truth_nxt == EXPECT && cnt_nxt == 5'd0;
               end else idx <= idx + 4'd1;
            end else wcnt <= wcnt + 4'd1;
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_kmap_sweep_checker.sv
// tb_kmap_sweep_checker: random and directed sweeps on SETTLE=1 and SETTLE=3 instances against a cycle-count model
module tb_kmap_sweep_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] start = 2'b11;
   logic [1:0] sop, pos, busy, done, pass;
   logic [1:0][3:0] x;
   logic [1:0][15:0] truth;
   logic [1:0][4:0] mm;
   logic [15:0] fn = 16'h0;
   logic [15:0] pf_drv [2] = '{16'h0, 16'h0};
   logic [15:0] sf_drv [2] = '{16'h0, 16'h0};
   logic [15:0] pf [2] = '{16'h0, 16'h0};
   logic [15:0] sf [2] = '{16'h0, 16'h0};
   logic glitch [2] = '{1'b0, 1'b0};
   logic glitch_en [2] = '{1'b0, 1'b1};
   int k [2] = '{-1, -1};
   int hv [2] = '{0, 0};
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   kmap_sweep_checker #(.SETTLE(1), .EXPECT(16'h5057)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .sop_in(sop[0]), .pos_in(pos[0]),
      .x1(x[0][3]), .x2(x[0][2]), .x3(x[0][1]), .x4(x[0][0]),
      .busy(busy[0]), .done(done[0]), .truth(truth[0]), .mismatch_cnt(mm[0]), .pass(pass[0]));
   kmap_sweep_checker #(.SETTLE(3), .EXPECT(16'h5057)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .sop_in(sop[1]), .pos_in(pos[1]),
      .x1(x[1][3]), .x2(x[1][2]), .x3(x[1][1]), .x4(x[1][0]),
      .busy(busy[1]), .done(done[1]), .truth(truth[1]), .mismatch_cnt(mm[1]), .pass(pass[1]));

   // stand-ins for the K-map blocks: the reference function with optional per-minterm faults
   for (genvar g = 0; g < 2; g++) begin : g_fn
      assign sop[g] = fn[x[g]] ^ sf_drv[g][x[g]];
      assign pos[g] = (fn[x[g]] ^ pf_drv[g][x[g]]) | glitch[g];
   end

   function automatic int sv(int n);
      return n == 0 ? 1 : 3;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: k = cycles since the accepting edge, hv = vectors captured by the last finished sweep
   always @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (!rst_n) begin
            k[n] <= -1;
            hv[n] <= 0;
         end else if (k[n] == 16 * sv(n)) begin
            k[n] <= -1;
            hv[n] <= 16;
         end else if (k[n] >= 0) k[n] <= k[n] + 1;
         else if (start[n]) begin
            k[n] <= 0;
            pf[n] <= pf_drv[n];
            sf[n] <= sf_drv[n];
         end
      end
   end

   always @(negedge clk) begin
      for (int n = 0; n < 2; n++) begin
         automatic int s = sv(n);
         automatic int v = k[n] < 0 ? hv[n] : k[n] / s;
         automatic logic [15:0] m = 16'((32'd1 << v) - 1);
         automatic logic [15:0] et = (fn ^ pf[n]) & m;
         automatic int em = $countones((sf[n] ^ pf[n]) & m);
         automatic logic ep = v == 16 && et == fn && em == 0;
         automatic logic [3:0] ex = k[n] < 0 ? 4'd0 : k[n] >= 16 * s ? 4'd15 : 4'(k[n] / s);
         chk($sformatf("x[%0d]", n), 32'(x[n]), 32'(ex));
         chk($sformatf("busy[%0d]", n), 32'(busy[n]), 32'(k[n] >= 0 && k[n] < 16 * s));
         chk($sformatf("done[%0d]", n), 32'(done[n]), 32'(k[n] == 16 * s));
         chk($sformatf("truth[%0d]", n), 32'(truth[n]), 32'(et));
         chk($sformatf("mismatch_cnt[%0d]", n), 32'(mm[n]), 32'(em));
         chk($sformatf("pass[%0d]", n), 32'(pass[n]), 32'(ep));
         glitch[n] <= glitch_en[n] && k[n] == 3 * s;
      end
   end

   task automatic step(int c);
      repeat (c) @(posedge clk);
      #2;
   endtask

   task automatic pulse(int n);
      start[n] = 1'b1;
      step(1);
      start[n] = 1'b0;
   endtask

   task automatic wait_done(int n);
      for (int c = 0; c < 200 && !done[n]; c++) step(1);
      chk($sformatf("wait_done[%0d]", n), 32'(done[n]), 32'd1);
   endtask

   initial begin
      automatic int mt[7] = '{0, 1, 2, 4, 6, 12, 14};
      foreach (mt[i]) fn[mt[i]] = 1'b1;
      step(2);
      chk("fn_pin", 32'(fn), 32'h5057);
      chk("rst_truth", 32'(truth[0]), 32'h0);
      chk("rst_busy", 32'(busy[1]), 32'h0);
      rst_n = 1'b1;
      start = 2'b00;
      step(3);
      pulse(0);
      wait_done(0);
      chk("nom_truth", 32'(truth[0]), 32'h5057);
      chk("nom_mm", 32'(mm[0]), 32'd0);
      chk("nom_pass", 32'(pass[0]), 32'd1);
      step(1);
      sf_drv[0] = 16'h8008;
      pulse(0);
      wait_done(0);
      chk("flt_truth", 32'(truth[0]), 32'h5057);
      chk("flt_mm", 32'(mm[0]), 32'd2);
      chk("flt_pass", 32'(pass[0]), 32'd0);
      step(1);
      pulse(1);
      step(5);
      pulse(1);
      wait_done(1);
      chk("s3_truth", 32'(truth[1]), 32'h5057);
      chk("s3_pass", 32'(pass[1]), 32'd1);
      step(1);
      pulse(1);
      for (int c = 0; c < 100 && x[1] != 4'd7; c++) step(1);
      chk("reach_v7", 32'(x[1]), 32'd7);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      chk("mid_rst_x", 32'(x[1]), 32'd0);
      chk("mid_rst_truth", 32'(truth[1]), 32'd0);
      pulse(1);
      wait_done(1);
      chk("after_rst_pass", 32'(pass[1]), 32'd1);
      step(1);
      start[0] = 1'b1;
      wait_done(0);
      chk("held1_mm", 32'(mm[0]), 32'd2);
      sf_drv[0] = 16'h0;
      step(1);
      wait_done(0);
      chk("held2_mm", 32'(mm[0]), 32'd0);
      chk("held2_pass", 32'(pass[0]), 32'd1);
      start[0] = 1'b0;
      for (int it = 0; it < 16; it++) begin
         automatic int n = int'($urandom_range(0, 1));
         step(1 + int'($urandom_range(0, 3)));
         sf_drv[n] = $urandom_range(0, 2) == 0 ? 16'h0 : 16'($urandom);
         pf_drv[n] = $urandom_range(0, 2) == 0 ? 16'h0 : 16'($urandom);
         pulse(n);
         if ($urandom_range(0, 1) == 1) begin
            step(int'($urandom_range(1, 8)));
            pulse(n);
         end
         wait_done(n);
      end
      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
